// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: next-PC/flush controls in, fetch address and F/D pipeline register out.
// The stage side uses the master modport; the surrounding pipeline uses slave.
interface fetch_pc_if;
    logic [31:0] next_pc;
    logic        redirect;
    logic        d_is_jump;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] imem_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_exc;
    logic        D_bd;

    modport master (
        input  next_pc, redirect, d_is_jump, stall, exc_req, eret_req, epc, imem_rdata,
        output F_pc, D_pc, D_instr, D_exc, D_bd
    );

    modport slave (
        output next_pc, redirect, d_is_jump, stall, exc_req, eret_req, epc, imem_rdata,
        input  F_pc, D_pc, D_instr, D_exc, D_bd
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// Fetch PC register and F/D pipeline register with AdEL detection and delay-slot tagging.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    fetch_pc_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [4:0]  d_exc_q, d_exc_d;
    logic        d_bd_q, d_bd_d;

    logic        f_bad;
    logic [4:0]  f_exc;
    logic [31:0] f_instr;
    logic        flush;

    // A bad fetch never lets memory data into D.
    assign f_bad   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_BASE) || (f_pc_q > IMEM_TOP);
    assign f_exc   = f_bad ? EXC_ADEL : 5'd0;
    assign f_instr = f_bad ? 32'd0 : bus.imem_rdata;
    assign flush   = bus.exc_req || bus.eret_req;

    always_comb begin
        f_pc_d    = f_pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_exc_d   = d_exc_q;
        d_bd_d    = d_bd_q;
        if (bus.exc_req) begin
            f_pc_d    = EXC_ENTRY;
            d_pc_d    = EXC_ENTRY;
            d_instr_d = 32'd0;
            d_exc_d   = 5'd0;
            d_bd_d    = 1'b0;
        end else if (bus.eret_req) begin
            f_pc_d    = bus.epc;
            d_pc_d    = bus.epc;
            d_instr_d = 32'd0;
            d_exc_d   = 5'd0;
            d_bd_d    = 1'b0;
        end else if (!bus.stall) begin
            // Sequential PC wraps mod 2^32; the range check catches it next cycle.
            f_pc_d    = bus.redirect ? bus.next_pc : f_pc_q + 32'd4;
            d_pc_d    = f_pc_q;
            d_instr_d = f_instr;
            d_exc_d   = f_exc;
            d_bd_d    = bus.d_is_jump;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_q    <= RESET_PC;
            d_pc_q    <= RESET_PC;
            d_instr_q <= 32'd0;
            d_exc_q   <= 5'd0;
            d_bd_q    <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_exc_q   <= d_exc_d;
            d_bd_q    <= d_bd_d;
        end
    end

    assign bus.F_pc    = f_pc_q;
    assign bus.D_pc    = d_pc_q;
    assign bus.D_instr = d_instr_q;
    assign bus.D_exc   = d_exc_q;
    assign bus.D_bd    = d_bd_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!flush) begin
            if (bus.stall) stall_cnt_d = stall_cnt_q + 32'd1;
            else           fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: per-cycle comparison against a behavioural model
// plus hand-computed literal checks. Define FETCH_PERF_CNT_EN to also cover the counters.
module tb_fetch_pc_stage;

    logic clk;
    logic reset;
    fetch_pc_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_pc_stage dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word at 0x3000 is 0x24080001, each next word +1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2408_0001 + ((a - 32'h0000_3000) >> 2);
    endfunction

    assign bus.imem_rdata = mem_word(bus.F_pc);

    function automatic bit legal_fetch(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
    endfunction

    // Behavioural model: next state follows the priority list directly.
    logic [31:0] m_fpc, m_dpc, m_dinstr, m_fcnt, m_scnt;
    logic [4:0]  m_dexc;
    logic        m_dbd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fpc <= 32'h3000; m_dpc <= 32'h3000; m_dinstr <= 0; m_dexc <= 0; m_dbd <= 0;
            m_fcnt <= 0; m_scnt <= 0;
        end else if (bus.exc_req || bus.eret_req) begin
            m_fpc    <= bus.exc_req ? 32'h4180 : bus.epc;
            m_dpc    <= bus.exc_req ? 32'h4180 : bus.epc;
            m_dinstr <= 0; m_dexc <= 0; m_dbd <= 0;
        end else if (bus.stall) begin
            m_scnt <= m_scnt + 1;
        end else begin
            m_fpc    <= bus.redirect ? bus.next_pc : m_fpc + 4;
            m_dpc    <= m_fpc;
            m_dinstr <= legal_fetch(m_fpc) ? mem_word(m_fpc) : 32'd0;
            m_dexc   <= legal_fetch(m_fpc) ? 5'd0 : 5'd4;
            m_dbd    <= bus.d_is_jump;
            m_fcnt   <= m_fcnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model F_pc", bus.F_pc, m_fpc);
            check("model D_pc", bus.D_pc, m_dpc);
            check("model D_instr", bus.D_instr, m_dinstr);
            check("model D_exc", {27'd0, bus.D_exc}, {27'd0, m_dexc});
            check("model D_bd", {31'd0, bus.D_bd}, {31'd0, m_dbd});
`ifdef FETCH_PERF_CNT_EN
            check("model fetch_cnt", fetch_cnt, m_fcnt);
            check("model stall_cnt", stall_cnt, m_scnt);
`endif
        end
    end

    // One clock edge with the given inputs; returns at the following falling edge.
    task automatic step(input logic rd, input logic [31:0] npc, input logic jmp,
                        input logic stl, input logic exc, input logic ert,
                        input logic [31:0] e);
        bus.redirect  = rd;
        bus.next_pc   = npc;
        bus.d_is_jump = jmp;
        bus.stall     = stl;
        bus.exc_req   = exc;
        bus.eret_req  = ert;
        bus.epc       = e;
        @(negedge clk);
    endtask

    task automatic seq();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jump_to(input logic [31:0] t);
        step(1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect = 0; bus.next_pc = 0; bus.d_is_jump = 0; bus.stall = 0;
        bus.exc_req = 0; bus.eret_req = 0; bus.epc = 0;
        #1 reset = 1'b0;
        #2;
        check("reset F_pc", bus.F_pc, 32'h3000);
        check("reset D_pc", bus.D_pc, 32'h3000);
        check("reset D_instr", bus.D_instr, 32'h0);
        check("reset D_exc", {27'd0, bus.D_exc}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1;

        // Sequential fetch
        seq();
        check("seq1 F_pc", bus.F_pc, 32'h3004);
        check("seq1 D_pc", bus.D_pc, 32'h3000);
        check("seq1 D_instr", bus.D_instr, 32'h2408_0001);
        seq();
        check("seq2 F_pc", bus.F_pc, 32'h3008);
        check("seq2 D_instr", bus.D_instr, 32'h2408_0002);
        seq(); seq(); seq();
        check("branch in D", bus.D_pc, 32'h3010);

        // Branch in D: F instruction is its delay slot
        step(1'b1, 32'h3040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("bd F_pc", bus.F_pc, 32'h3040);
        check("bd D_pc", bus.D_pc, 32'h3014);
        check("bd D_bd", {31'd0, bus.D_bd}, 32'h1);
        seq();
        check("after bd D_bd", {31'd0, bus.D_bd}, 32'h0);
        check("after bd D_instr", bus.D_instr, 32'h2408_0011);

        // Misaligned and out-of-range targets
        jump_to(32'h3042);
        check("mis F_pc", bus.F_pc, 32'h3042);
        seq();
        check("mis D_pc", bus.D_pc, 32'h3042);
        check("mis D_exc", {27'd0, bus.D_exc}, 32'h4);
        check("mis D_instr", bus.D_instr, 32'h0);
        jump_to(32'h7000);
        seq();
        check("above top D_exc", {27'd0, bus.D_exc}, 32'h4);
        jump_to(32'h6FFC);
        seq();
        check("top D_exc", {27'd0, bus.D_exc}, 32'h0);
        check("top D_instr", bus.D_instr, 32'h2408_1000);
        jump_to(32'h2FFC);
        seq();
        check("below base D_exc", {27'd0, bus.D_exc}, 32'h4);

        // Stall holds everything and drops redirect
        jump_to(32'h3020);
        check("pre-stall D_pc", bus.D_pc, 32'h3000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h3100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check("stall F_pc", bus.F_pc, 32'h3020);
            check("stall D_pc", bus.D_pc, 32'h3000);
            check("stall D_instr", bus.D_instr, 32'h2408_0001);
        end
        seq();
        check("unstall F_pc", bus.F_pc, 32'h3024);
        check("unstall D_instr", bus.D_instr, 32'h2408_0009);

        // Flush priorities
        step(1'b1, 32'h3100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3058);
        check("exc F_pc", bus.F_pc, 32'h4180);
        check("exc D_pc", bus.D_pc, 32'h4180);
        check("exc D_instr", bus.D_instr, 32'h0);
        check("exc D_bd", {31'd0, bus.D_bd}, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3058);
        check("eret F_pc", bus.F_pc, 32'h3058);
        check("eret D_instr", bus.D_instr, 32'h0);
        seq();
        check("post eret D_instr", bus.D_instr, 32'h2408_0017);

        // PC wrap is caught by the range check
        jump_to(32'hFFFF_FFFC);
        seq();
        check("wrap F_pc", bus.F_pc, 32'h0);
        check("wrap D_exc", {27'd0, bus.D_exc}, 32'h4);
        seq();
        check("wrap2 D_pc", bus.D_pc, 32'h0);

        // Asynchronous reset between edges
        jump_to(32'h3100);
        seq();
        check("pre-reset D_instr", bus.D_instr, 32'h2408_0041);
        #2 reset = 1'b0;
        #1;
        check("async F_pc", bus.F_pc, 32'h3000);
        check("async D_pc", bus.D_pc, 32'h3000);
        check("async D_instr", bus.D_instr, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) seq();
        check("cnt F_pc", bus.F_pc, 32'h3028);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'd10);
        check("stall_cnt", stall_cnt, 32'd2);
`endif
        seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
